irq_pending_latch: RTL and testbench
====================================

Name: irq_pending_latch

Overview:
- Request front-end that feeds the 8-input priority encoder directly downstream.
- Synchronises 8 asynchronous interrupt lines and captures rising edges into a sticky pending register. Applies a mask and presents a registered request vector plus enable to the encoder.
- A valid/ack/end-of-interrupt handshake with the service controller clears the serviced bit and holds off new requests while one is in service.
- Bit 7 is highest priority. Encoder code c corresponds to bit 7-c (code 3'b000 = bit 7, code 3'b111 = bit 0).

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the per-line input synchroniser; legal values 2 and 3.
- LEVEL_MODE, 0, 0 = rising-edge capture into pending; 1 = pending follows the synchronised level, and ack does not clear it.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- irq_in  input  8  asynchronous interrupt lines, active high.
- mask  input  8  synchronous; 1 hides that bit from req_out but does not stop capture.
- clr_all  input  1  synchronous; clears all pending bits and returns the FSM to IDLE.
- req_out  output  8  registered pending & ~mask; drives the encoder in[7:0].
- en_out  output  1  registered; drives the encoder en; 1 only in state REQ.
- irq_valid  output  1  registered; 1 in state REQ.
- ack  input  1  service controller accepts the current request.
- ack_code  input  3  encoder output y sampled by the controller together with ack.
- eoi  input  1  end of interrupt; releases SERVICE.
- in_service  output  8  one-hot bit currently being serviced; 0 when none.

Behaviour:
- Reset, asynchronous and active-low: synchroniser flops, edge-history and pending are cleared to 0. Outputs go to req_out=0, en_out=0, irq_valid=0, in_service=0, and the FSM enters IDLE. Deassertion takes effect at the next clock edge.
- Capture latency, edge mode: an irq_in rising edge set up before clock edge 1 sets pending at edge SYNC_STAGES+1. req_out, irq_valid and en_out reflect it at edge SYNC_STAGES+2, which is 4 cycles at the default.
- Pulse width: irq_in pulses shorter than one clock period may be lost; the minimum guaranteed pulse is 2 clocks.
- Pending update per bit, in priority order:
  - clr_all clears it.
  - Otherwise a detected edge sets it.
  - Otherwise a valid ack to this bit clears it.
  - Otherwise it holds.
  - A new edge coinciding with an ack to the same bit leaves the bit set.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE -> REQ when (pending & ~mask) != 0.
  - REQ -> IDLE when (pending & ~mask) becomes 0, e.g. due to a mask change. No ack is needed in this case.
  - REQ -> SERVICE on ack=1 with pending[7-ack_code]=1 and mask[7-ack_code]=0. That pending bit is cleared (edge mode) and in_service <= one-hot(7-ack_code).
  - REQ stays in REQ on ack whose target bit is not pending or is masked. The ack is ignored and no state changes.
  - SERVICE -> IDLE on eoi=1: in_service <= 0. Re-entry to REQ occurs on the following cycle if requests remain.
  - eoi outside SERVICE and ack outside REQ are ignored.
- In SERVICE: irq_valid=0 and en_out=0. req_out still shows pending & ~mask. Capture continues.
- clr_all in any state clears pending, clears in_service and forces IDLE. clr_all has priority over a simultaneous ack or eoi.
- Mask changes take effect on req_out, irq_valid and en_out one clock after sampling.
- LEVEL_MODE=1:
  - pending = synchronised level.
  - ack does not clear pending.
  - While in SERVICE, the bit in service is excluded from REQ re-entry until eoi.

Test Plan:
- Reset with irq_in=8'hFF held -> all outputs 0; after rst_n rises, edges are seen only on a fresh 0->1 transition. Toggle irq_in[5] 0->1 -> req_out=8'h20 and irq_valid=1 exactly 4 clocks later.
- irq_in=8'h81 rising together -> req_out=8'h81. Ack with ack_code=3'b000 -> in_service=8'h80, req_out=8'h01, irq_valid=0. eoi -> IDLE, then REQ next cycle with irq_valid=1.
- mask=8'h80 with irq_in[7] and irq_in[2] rising -> req_out=8'h04. Clear mask -> req_out=8'h84 one clock later.
- In REQ with req_out=8'h04, ack with ack_code=3'b000 (bit 7 not pending) -> ignored: state stays REQ and in_service=0.
- Second rising edge on bit 3 in the same cycle as an ack to bit 3 -> pending[3] remains 1, and REQ is re-entered after eoi.
- clr_all in SERVICE with pending=8'h30 -> next clock pending=0, in_service=0, irq_valid=0, state IDLE. rst_n pulsed low mid-SERVICE -> outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/irq_pending_latch.sv
// irq_pending_latch: synchronised sticky interrupt pending register with mask and ack/eoi service handshake
module irq_pending_latch #(
  parameter int SYNC_STAGES = 2,
  parameter bit LEVEL_MODE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_in,
  input  logic [7:0] mask,
  input  logic       clr_all,
  output logic [7:0] req_out,
  output logic       en_out,
  output logic       irq_valid,
  input  logic       ack,
  input  logic [2:0] ack_code,
  input  logic       eoi,
  output logic [7:0] in_service
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
  logic [SYNC_STAGES:0] arm_q, arm_d;
  logic [7:0] prev_q, prev_d, pending_q, pending_d, req_out_q, req_out_d, in_service_q, in_service_d;
  logic valid_q, valid_d;
  logic [7:0] synced, edges, avail, ack_oh, ack_clr;
  logic ack_ok;
  // arm_q holds off edge detection until the synchroniser has flushed, so lines high across reset are not edges
  always_comb begin
    synced = sync_q[SYNC_STAGES-1];
    sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
    arm_d = {arm_q[SYNC_STAGES-1:0], 1'b1};
    prev_d = synced;
    edges = arm_q[SYNC_STAGES] ? synced & ~prev_q : '0;
    avail = pending_q & ~mask & ~in_service_q;
    ack_oh = 8'h80 >> ack_code;
    ack_ok = state_q == REQ && ack && |(ack_oh & avail);
    ack_clr = (ack_ok && !LEVEL_MODE) ? ack_oh : '0;
    pending_d = clr_all ? '0 : LEVEL_MODE ? synced : (pending_q & ~ack_clr) | edges;
    state_d = clr_all ? IDLE :
              state_q == IDLE ? (|avail ? REQ : IDLE) :
              state_q == REQ ? (ack_ok ? SERVICE : |avail ? REQ : IDLE) :
              eoi ? IDLE : SERVICE;
    in_service_d = clr_all ? '0 : ack_ok ? ack_oh : (state_q == SERVICE && eoi) ? '0 : in_service_q;
    req_out_d = clr_all ? '0 : pending_q & ~mask & ~ack_clr;
    valid_d = state_d == REQ;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q <= '0;
      arm_q <= '0;
      prev_q <= '0;
      pending_q <= '0;
      req_out_q <= '0;
      in_service_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      arm_q <= arm_d;
      prev_q <= prev_d;
      pending_q <= pending_d;
      req_out_q <= req_out_d;
      in_service_q <= in_service_d;
      valid_q <= valid_d;
    end
  end
  assign req_out = req_out_q;
  assign en_out = valid_q;
  assign irq_valid = valid_q;
  assign in_service = in_service_q;
endmodule

// File: tb/tb_irq_pending_latch.sv
// tb_irq_pending_latch: directed scenarios for irq_pending_latch with hand-computed expectations
module tb_irq_pending_latch;
  logic clk = 0, rst_n = 0, clr_all = 0, ack = 0, eoi = 0;
  logic [7:0] irq_in = 8'hFF, mask = 0;
  logic [2:0] ack_code = 0;
  logic [7:0] req_out, in_service;
  logic en_out, irq_valid;
  int checks = 0, fails = 0;

  irq_pending_latch dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask(mask), .clr_all(clr_all),
    .req_out(req_out), .en_out(en_out), .irq_valid(irq_valid), .ack(ack),
    .ack_code(ack_code), .eoi(eoi), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clean();
    irq_in = 0;
    mask = 0;
    clr_all = 1;
    tick();
    clr_all = 0;
    tick(3);
  endtask

  task automatic test_reset();
    #12;
    checks++; if (req_out !== 8'h00) begin fails++; $display("FAIL rst_req_out: got %h want 00", req_out); end
    checks++; if ({irq_valid, en_out} !== 2'b00) begin fails++; $display("FAIL rst_valid_en: got %b want 00", {irq_valid, en_out}); end
    checks++; if (in_service !== 8'h00) begin fails++; $display("FAIL rst_in_service: got %h want 00", in_service); end
    tick();
    rst_n = 1;
    tick(6);
    checks++; if ({req_out, irq_valid} !== 9'h000) begin fails++; $display("FAIL held_high_no_edge: got %h want 000", {req_out, irq_valid}); end
    irq_in = 0;
    tick(4);
    irq_in = 8'h20;
    tick(3);
    checks++; if ({req_out, irq_valid} !== 9'h000) begin fails++; $display("FAIL latency_early: got %h want 000", {req_out, irq_valid}); end
    tick();
    checks++; if (req_out !== 8'h20) begin fails++; $display("FAIL latency_req_out: got %h want 20", req_out); end
    checks++; if ({irq_valid, en_out} !== 2'b11) begin fails++; $display("FAIL latency_valid_en: got %b want 11", {irq_valid, en_out}); end
  endtask

  task automatic test_ack_eoi();
    clean();
    irq_in = 8'h81;
    tick(4);
    checks++; if (req_out !== 8'h81) begin fails++; $display("FAIL two_req_out: got %h want 81", req_out); end
    ack = 1; ack_code = 3'b000;
    tick();
    ack = 0;
    checks++; if (in_service !== 8'h80) begin fails++; $display("FAIL ack_in_service: got %h want 80", in_service); end
    checks++; if (req_out !== 8'h01) begin fails++; $display("FAIL ack_req_out: got %h want 01", req_out); end
    checks++; if ({irq_valid, en_out} !== 2'b00) begin fails++; $display("FAIL service_valid_en: got %b want 00", {irq_valid, en_out}); end
    eoi = 1;
    tick();
    eoi = 0;
    checks++; if ({in_service, irq_valid} !== 9'h000) begin fails++; $display("FAIL eoi_idle: got %h want 000", {in_service, irq_valid}); end
    tick();
    checks++; if ({req_out, irq_valid, en_out} !== 10'b0000000111) begin fails++; $display("FAIL eoi_reenter: got %b want 0000000111", {req_out, irq_valid, en_out}); end
  endtask

  task automatic test_mask();
    clean();
    mask = 8'h80;
    irq_in = 8'h84;
    tick(4);
    checks++; if ({req_out, irq_valid} !== {8'h04, 1'b1}) begin fails++; $display("FAIL masked_req: got %h want 009", {req_out, irq_valid}); end
    mask = 8'h00;
    tick();
    checks++; if (req_out !== 8'h84) begin fails++; $display("FAIL unmask_req: got %h want 84", req_out); end
    mask = 8'hFF;
    tick();
    checks++; if ({req_out, irq_valid, en_out} !== 10'b0) begin fails++; $display("FAIL mask_all_idle: got %b want 0", {req_out, irq_valid, en_out}); end
    mask = 8'h00;
    tick();
    checks++; if ({req_out, irq_valid} !== {8'h84, 1'b1}) begin fails++; $display("FAIL remask_req: got %h want 109", {req_out, irq_valid}); end
  endtask

  task automatic test_ignored_ack();
    clean();
    irq_in = 8'h04;
    tick(4);
    ack = 1; ack_code = 3'b000;
    tick();
    ack = 0;
    checks++; if ({in_service, irq_valid} !== 9'h001) begin fails++; $display("FAIL ignored_ack: got %h want 001", {in_service, irq_valid}); end
    eoi = 1;
    tick();
    eoi = 0;
    checks++; if ({req_out, irq_valid} !== {8'h04, 1'b1}) begin fails++; $display("FAIL stray_eoi: got %h want 009", {req_out, irq_valid}); end
  endtask

  task automatic test_back_to_back();
    clean();
    irq_in = 8'h08;
    tick(4);
    irq_in = 8'h00;
    tick(3);
    checks++; if ({req_out, irq_valid} !== {8'h08, 1'b1}) begin fails++; $display("FAIL sticky_pending: got %h want 011", {req_out, irq_valid}); end
    irq_in = 8'h08;
    tick(2);
    ack = 1; ack_code = 3'd4;
    tick();
    ack = 0;
    checks++; if ({in_service, irq_valid} !== {8'h08, 1'b0}) begin fails++; $display("FAIL edge_ack_service: got %h want 010", {in_service, irq_valid}); end
    tick();
    checks++; if (req_out !== 8'h08) begin fails++; $display("FAIL edge_beats_ack: got %h want 08", req_out); end
    eoi = 1;
    tick();
    eoi = 0;
    checks++; if ({in_service, irq_valid} !== 9'h000) begin fails++; $display("FAIL b2b_eoi: got %h want 000", {in_service, irq_valid}); end
    tick();
    checks++; if ({req_out, irq_valid} !== {8'h08, 1'b1}) begin fails++; $display("FAIL b2b_reenter: got %h want 011", {req_out, irq_valid}); end
  endtask

  task automatic test_clr_all();
    clean();
    irq_in = 8'h80;
    tick(4);
    ack = 1; ack_code = 3'b000;
    tick();
    ack = 0;
    irq_in = 8'hB0;
    tick(4);
    checks++; if ({req_out, in_service, irq_valid} !== {8'h30, 8'h80, 1'b0}) begin fails++; $display("FAIL capture_in_service: got %h want 06100", {req_out, in_service, irq_valid}); end
    clr_all = 1;
    tick();
    clr_all = 0;
    checks++; if ({req_out, in_service, irq_valid} !== 17'h0) begin fails++; $display("FAIL clr_all: got %h want 0", {req_out, in_service, irq_valid}); end
    tick(2);
    checks++; if ({req_out, irq_valid} !== 9'h000) begin fails++; $display("FAIL clr_all_idle: got %h want 000", {req_out, irq_valid}); end
  endtask

  task automatic test_async_reset();
    clean();
    irq_in = 8'h02;
    tick(4);
    ack = 1; ack_code = 3'd6;
    tick();
    ack = 0;
    checks++; if (in_service !== 8'h02) begin fails++; $display("FAIL pre_reset_service: got %h want 02", in_service); end
    #3;
    rst_n = 0;
    #1;
    checks++; if ({req_out, in_service, irq_valid, en_out} !== 18'h0) begin fails++; $display("FAIL async_reset: got %h want 0", {req_out, in_service, irq_valid, en_out}); end
    tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_ack_eoi();
    test_mask();
    test_ignored_ack();
    test_back_to_back();
    test_clr_all();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
